hamming_rx_deframer: RTL



---
 rtl/hamming_rx_deframer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hamming_rx_deframer.sv
// Serial-to-parallel deframer feeding the Hamming(7,4) decoder: start bit, 7 code bits LSB first, stop bit.
// Optional macro HAM_RX_PARITY_EN adds an even-parity bit after cw[6] and a parity_err output.
module hamming_rx_deframer #(
  parameter int   TIMEOUT  = 16,
  parameter logic STOP_VAL = 1'b0,
  parameter int   TO_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_bit,
  input  logic       rx_valid,
  output logic [6:0] cw_data,
  output logic       cw_valid,
  input  logic       cw_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef HAM_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

`ifdef HAM_RX_PARITY_EN
  localparam logic [2:0] LAST_IDX = 3'd7;
`else
  localparam logic [2:0] LAST_IDX = 3'd6;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        bit_cnt;
  logic [6:0]        shift_reg;
  logic [TO_W-1:0]   to_cnt;
  logic              to_hit;
  logic              frame_done;
  logic              stop_bad;
  logic              can_load;
`ifdef HAM_RX_PARITY_EN
  logic              par_bit;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
    // Abort on the idle cycle that would bring the gap counter up to TIMEOUT
    to_hit = (TIMEOUT != 0) && (state != IDLE) && !rx_valid &&
             (to_cnt == TO_W'(TIMEOUT - 1));
    case (state)
      IDLE: begin
        if (rx_valid && rx_bit) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (to_hit)                                state_nxt = IDLE;
        else if (rx_valid && bit_cnt == LAST_IDX)  state_nxt = STOP;
      end
      STOP: begin
        if (to_hit) begin
          state_nxt = IDLE;
        end else if (rx_valid) begin
          state_nxt = IDLE;
          if (rx_bit == STOP_VAL) frame_done = 1'b1;
          else                    stop_bad   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    can_load = frame_done && (!cw_valid || cw_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift_reg  <= 7'd0;
      to_cnt     <= '0;
      cw_data    <= 7'd0;
      cw_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef HAM_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      frame_err <= stop_bad | to_hit;
      overrun   <= frame_done & ~can_load;

      if (state == IDLE || rx_valid || to_hit) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + 1'b1;

      if (state != SHIFT) begin
        bit_cnt <= 3'd0;
      end else if (rx_valid) begin
        bit_cnt <= bit_cnt + 3'd1;
`ifdef HAM_RX_PARITY_EN
        if (bit_cnt == 3'd7) par_bit <= rx_bit;
        else                 shift_reg[bit_cnt] <= rx_bit;
`else
        shift_reg[bit_cnt] <= rx_bit;
`endif
      end

      // A completing frame may replace a codeword being consumed this same cycle
      if (can_load) begin
        cw_data    <= shift_reg;
        cw_valid   <= 1'b1;
`ifdef HAM_RX_PARITY_EN
        parity_err <= ^{shift_reg, par_bit};
`endif
      end else if (cw_valid && cw_ready) begin
        cw_valid <= 1'b0;
      end
    end
  end

endmodule
